auth_sequencer: RTL and testbench



---
 rtl/auth_sequencer.sv | 150 +++++++++++++++
 tb/tb_auth_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_sequencer.sv
`default_nettype none
// ==== auth_sequencer : press/release code entry with escalating lockout -- rev 1.0 ====
module auth_sequencer #(
  parameter logic [31:0] KEY           = 32'hA53C0F96,
  parameter int          KEY_LEN       = 4,
  parameter int          MAX_FAILS     = 3,
  parameter int          LOCKOUT_BASE  = 1_048_576,
  parameter int          UNLOCK_HOLD   = 2_500_000,
  parameter int          ENTRY_TIMEOUT = 250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sig_in,
  output logic       unlocked,
  output logic       lockout_active,
  output logic       alarm,
  output logic [1:0] fail_count,
  output logic [1:0] digit_idx
);

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_WAIT_REL = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  localparam logic [2:0]  KEY_LEN_W   = 3'(KEY_LEN);
  localparam logic [2:0]  MAX_FAILS_W = 3'(MAX_FAILS);
  localparam logic [23:0] BASE_W      = 24'(LOCKOUT_BASE);
  localparam logic [23:0] HOLD_LAST   = 24'(UNLOCK_HOLD - 1);
  localparam logic [23:0] ENTRY_LAST  = 24'(ENTRY_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  sig_q;
  logic [2:0]  idx;
  logic        mismatch;
  logic [1:0]  lock_level;
  logic [23:0] timer;
  logic [23:0] lock_dur;
  logic [7:0]  key_digit;
  logic        capture;
  logic        released;
  logic        entry_expired;
  logic [2:0]  fails_next;

  always_comb begin
    case (idx[1:0])
      2'd0:    key_digit = KEY[31:24];
      2'd1:    key_digit = KEY[23:16];
      2'd2:    key_digit = KEY[15:8];
      default: key_digit = KEY[7:0];
    endcase
  end

  // A digit is taken only once the same non-zero byte is seen on two enabled edges.
  assign capture       = (sig_in != 8'h00) && (sig_in == sig_q);
  assign released      = (sig_in == 8'h00);
  assign entry_expired = (idx != 3'd0) && (timer == ENTRY_LAST);
  assign fails_next    = {1'b0, fail_count} + 3'd1;
  assign digit_idx     = idx[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_WAIT_REL;
      sig_q          <= 8'h00;
      idx            <= 3'd0;
      mismatch       <= 1'b0;
      fail_count     <= 2'd0;
      lock_level     <= 2'd0;
      timer          <= 24'd0;
      lock_dur       <= 24'd0;
      unlocked       <= 1'b0;
      lockout_active <= 1'b0;
      alarm          <= 1'b0;
    end else if (ena) begin
      sig_q <= sig_in;
      case (state)
        S_READY: begin
          if (capture) begin
            if (sig_in != key_digit) mismatch <= 1'b1;
            idx   <= idx + 3'd1;
            timer <= 24'd0;
            state <= S_WAIT_REL;
          end else if (entry_expired) begin
            idx      <= 3'd0;
            mismatch <= 1'b0;
            timer    <= 24'd0;
            state    <= S_WAIT_REL;
          end else if (idx != 3'd0) begin
            timer <= timer + 24'd1;
          end
        end
        S_WAIT_REL: begin
          if (released && (idx == KEY_LEN_W)) begin
            idx      <= 3'd0;
            mismatch <= 1'b0;
            timer    <= 24'd0;
            if (!mismatch) begin
              state      <= S_UNLOCKED;
              unlocked   <= 1'b1;
              fail_count <= 2'd0;
              lock_level <= 2'd0;
              alarm      <= 1'b0;
            end else if (fails_next < MAX_FAILS_W) begin
              fail_count <= fail_count + 2'd1;
              state      <= S_READY;
            end else begin
              state          <= S_LOCKOUT;
              lockout_active <= 1'b1;
              lock_dur       <= BASE_W << lock_level;
              fail_count     <= 2'd0;
              if (lock_level == 2'd3) alarm <= 1'b1;
              else lock_level <= lock_level + 2'd1;
            end
          end else if (entry_expired) begin
            idx      <= 3'd0;
            mismatch <= 1'b0;
            timer    <= 24'd0;
          end else begin
            if (released) state <= S_READY;
            if (idx != 3'd0) timer <= timer + 24'd1;
          end
        end
        S_UNLOCKED: begin
          if (timer == HOLD_LAST) begin
            state    <= S_WAIT_REL;
            unlocked <= 1'b0;
            timer    <= 24'd0;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        S_LOCKOUT: begin
          if (timer == (lock_dur - 24'd1)) begin
            state          <= S_WAIT_REL;
            lockout_active <= 1'b0;
            timer          <= 24'd0;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        default: state <= S_WAIT_REL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_auth_sequencer.sv
`default_nettype none
// ==== tb_auth_sequencer : bench for auth_sequencer (LOCKOUT_BASE=16, UNLOCK_HOLD=32, ENTRY_TIMEOUT=64) -- rev 1.0 ====
module tb_auth_sequencer;

  localparam logic [31:0] KEY = 32'hA53C0F96;
  localparam logic [31:0] BAD = 32'hA53C0F97;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] sig_in = 8'hA5;
  logic       unlocked;
  logic       lockout_active;
  logic       alarm;
  logic [1:0] fail_count;
  logic [1:0] digit_idx;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] sig;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];

  auth_sequencer #(
    .KEY          (KEY),
    .KEY_LEN      (4),
    .MAX_FAILS    (3),
    .LOCKOUT_BASE (16),
    .UNLOCK_HOLD  (32),
    .ENTRY_TIMEOUT(64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .sig_in        (sig_in),
    .unlocked      (unlocked),
    .lockout_active(lockout_active),
    .alarm         (alarm),
    .fail_count    (fail_count),
    .digit_idx     (digit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d so far", passed, total);
    $fatal(1);
  end

  function automatic logic [6:0] outs();
    return {unlocked, lockout_active, alarm, fail_count, digit_idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic addn(input logic r, input logic [7:0] s, input logic [1:0] i, input int cnt);
    vec_t v;
    v.rst_n = r;
    v.sig   = s;
    v.exp   = {5'b00000, i};
    repeat (cnt) vecs.push_back(v);
  endtask

  task automatic idle(input int cnt);
    sig_in = 8'h00;
    repeat (cnt) tick();
  endtask

  // Digits first..3 of k, each held 3 cycles; the final release stops on the evaluate edge.
  task automatic enter(input logic [31:0] k, input int first);
    idle(2);
    for (int d = first; d < 4; d++) begin
      sig_in = k[31-8*d -: 8];
      repeat (3) tick();
      sig_in = 8'h00;
      if (d == 3) tick();
      else repeat (3) tick();
    end
  endtask

  // Counts edges the selected output stays high, starting from the edge already sampled high.
  task automatic measure(input bit sel, input logic [7:0] s, input int gap,
                         output int n, output bit moved);
    bit done;
    done  = 1'b0;
    n     = 1;
    moved = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      sig_in = (c < 6) ? s : 8'h00;
      ena    = !(c >= 5 && c < 5 + gap);
      tick();
      if (digit_idx != 2'd0) moved = 1'b1;
      if ((sel ? lockout_active : unlocked) == 1'b1) n++;
      else done = 1'b1;
    end
    ena    = 1'b1;
    sig_in = 8'h00;
  endtask

  task automatic lockout_cycle(input int dur, input logic exp_alarm,
                               input logic [7:0] s, input int gap);
    int n;
    bit moved;
    for (int a = 1; a <= 3; a++) begin
      enter(BAD, 0);
      if (a < 3) chk("fail_count_step", fail_count, a);
    end
    chk("lockout_rise", lockout_active, 1);
    chk("fail_count_cleared", fail_count, 0);
    chk("alarm_at_lockout", alarm, exp_alarm);
    measure(1'b1, s, gap, n, moved);
    chk("lockout_len", n, dur + gap);
    chk("lockout_no_capture", moved, 0);
  endtask

  initial begin
    int n;
    bit moved;

    // Reset with A5 held, release, then the correct code entered press/release.
    addn(1'b0, 8'hA5, 2'd0, 2);
    addn(1'b1, 8'hA5, 2'd0, 2);
    addn(1'b1, 8'h00, 2'd0, 2);
    addn(1'b1, 8'hA5, 2'd0, 1);
    addn(1'b1, 8'hA5, 2'd1, 2);
    addn(1'b1, 8'h00, 2'd1, 3);
    addn(1'b1, 8'h3C, 2'd1, 1);
    addn(1'b1, 8'h3C, 2'd2, 2);
    addn(1'b1, 8'h00, 2'd2, 3);
    addn(1'b1, 8'h0F, 2'd2, 1);
    addn(1'b1, 8'h0F, 2'd3, 2);
    addn(1'b1, 8'h00, 2'd3, 3);
    addn(1'b1, 8'h96, 2'd3, 1);
    addn(1'b1, 8'h96, 2'd0, 2);

    foreach (vecs[k]) begin
      rst_n  = vecs[k].rst_n;
      sig_in = vecs[k].sig;
      exp_q.push_back(vecs[k].exp);
      tick();
      chk($sformatf("vec%0d", k), outs(), exp_q.pop_front());
    end

    sig_in = 8'h00;
    tick();
    chk("t1_unlock_rise", unlocked, 1);
    chk("t1_fail_count", fail_count, 0);
    measure(1'b0, 8'h00, 0, n, moved);
    chk("t1_unlock_len", n, 32);

    // Escalating lockouts; input pressed during the first one.
    lockout_cycle(16, 1'b0, 8'hA5, 0);
    lockout_cycle(32, 1'b0, 8'h00, 0);
    lockout_cycle(64, 1'b0, 8'h00, 0);
    lockout_cycle(128, 1'b1, 8'h00, 0);
    lockout_cycle(128, 1'b1, 8'h00, 0);
    enter(KEY, 0);
    chk("t3_unlock_rise", unlocked, 1);
    chk("t3_alarm_cleared", alarm, 0);
    measure(1'b0, 8'h00, 0, n, moved);
    chk("t3_unlock_len", n, 32);

    // Partial entry abandoned exactly ENTRY_TIMEOUT cycles after the capture.
    enter(BAD, 0);
    chk("t4_fail_one", fail_count, 1);
    idle(2);
    sig_in = 8'hA5;
    tick();
    tick();
    chk("t4_captured", digit_idx, 1);
    sig_in = 8'h00;
    repeat (63) tick();
    chk("t4_before_timeout", digit_idx, 1);
    tick();
    chk("t4_after_timeout", digit_idx, 0);
    chk("t4_fail_kept", fail_count, 1);
    enter(KEY, 0);
    chk("t4_unlock", unlocked, 1);
    chk("t4_fail_cleared", fail_count, 0);
    measure(1'b0, 8'h00, 0, n, moved);
    chk("t4_unlock_len", n, 32);

    // Byte changing every cycle, then a settling ramp.
    moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sig_in = (i % 2 == 0) ? 8'hA5 : 8'h00;
      tick();
      if (digit_idx != 2'd0) moved = 1'b1;
    end
    chk("t5_toggle_no_capture", moved, 0);
    sig_in = 8'h01; tick();
    sig_in = 8'h05; tick();
    sig_in = 8'h25; tick();
    sig_in = 8'hA5; tick();
    chk("t5_ramp_not_yet", digit_idx, 0);
    tick();
    chk("t5_ramp_capture", digit_idx, 1);
    repeat (2) tick();
    chk("t5_single_capture", digit_idx, 1);
    sig_in = 8'h00;
    tick();
    enter(KEY, 1);
    chk("t5_unlock", unlocked, 1);
    measure(1'b0, 8'h00, 0, n, moved);
    chk("t5_unlock_len", n, 32);

    // ena low for 20 cycles stretches the lockout; then reset mid-lockout.
    lockout_cycle(16, 1'b0, 8'h00, 20);
    for (int a = 0; a < 3; a++) enter(BAD, 0);
    chk("t6_second_lockout", lockout_active, 1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_after_reset", outs(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
